// File: rtl/move_controller.sv
// move_controller: converts mouse pixel coordinates and left-clicks into
// pick_piece / place_piece strobes plus a square address for chess_board.
// Tracks the side to move, validates picks by piece colour and drops by the
// possible_moves mask, counts completed moves and freezes once a win is flagged.
// Optional feature macro: TURN_ENFORCE_EN (restricts picks to the side to move).
module move_controller #(
   parameter int BOARD_X0 = 0,
   parameter int BOARD_Y0 = 0,
   parameter int SQ_SHIFT = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] xpos,
   input  logic [11:0] ypos,
   input  logic        mouse_left,
   input  logic [3:0]  piece_code,
   input  logic [63:0] possible_moves,
   input  logic        white_win,
   input  logic        black_win,
   output logic [5:0]  query_pos,
   output logic [5:0]  figure_position,
   output logic        pick_piece,
   output logic        place_piece,
   output logic        side_to_move,
   output logic        sel_valid,
   output logic [5:0]  sel_pos,
   output logic        illegal_click,
   output logic [9:0]  move_count
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      CHECK  = 3'd2,
      HOLD   = 3'd3,
      OVER   = 3'd4
   } state_t;

   state_t      state;
   logic [2:0]  ml_sync;
   logic        click;
   logic [11:0] dx;
   logic [11:0] dy;
   logic [11:0] col_full;
   logic [11:0] row_full;
   logic        on_board;
   logic [5:0]  sq;
   logic        is_white;
   logic        is_black;
   logic        pickable;

   // Move counter stops at its maximum instead of wrapping.
   function automatic logic [9:0] sat_inc(input logic [9:0] v);
      return (v == 10'd1023) ? v : v + 10'd1;
   endfunction

   // Two-stage synchroniser plus one delayed copy for rising-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ml_sync <= 3'b000;
      else      ml_sync <= {ml_sync[1:0], mouse_left};
   end

   assign click = ml_sync[1] & ~ml_sync[2];

   // Pixel to square mapping; anything left of / above the origin or past the
   // eighth file/rank is off-board.
   always_comb begin
      dx       = xpos - 12'(BOARD_X0);
      dy       = ypos - 12'(BOARD_Y0);
      col_full = dx >> SQ_SHIFT;
      row_full = dy >> SQ_SHIFT;
      on_board = (xpos >= 12'(BOARD_X0)) && (ypos >= 12'(BOARD_Y0)) &&
                 (col_full <= 12'd7) && (row_full <= 12'd7);
      sq       = {row_full[2:0], col_full[2:0]};
   end

   // Piece colour classification; 0 and D (highlight) count as empty.
   always_comb begin
      is_white = (piece_code >= 4'd1) && (piece_code <= 4'd6);
      is_black = (piece_code >= 4'd7) && (piece_code <= 4'd12);
`ifdef TURN_ENFORCE_EN
      pickable = side_to_move ? is_black : is_white;
`else
      pickable = is_white | is_black;
`endif
   end

   // Main FSM with registered strobes; a win flag overrides every state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         query_pos       <= 6'd0;
         figure_position <= 6'd0;
         pick_piece      <= 1'b0;
         place_piece     <= 1'b0;
         side_to_move    <= 1'b0;
         sel_valid       <= 1'b0;
         sel_pos         <= 6'd0;
         illegal_click   <= 1'b0;
         move_count      <= 10'd0;
      end else begin
         pick_piece    <= 1'b0;
         place_piece   <= 1'b0;
         illegal_click <= 1'b0;
         if (white_win || black_win) begin
            state <= OVER;
         end else begin
            case (state)
               IDLE: begin
                  if (click && on_board) begin
                     query_pos <= sq;
                     state     <= LOOKUP;
                  end
               end
               LOOKUP: state <= CHECK;
               CHECK: begin
                  if (pickable) begin
                     pick_piece      <= 1'b1;
                     figure_position <= query_pos;
                     sel_pos         <= query_pos;
                     sel_valid       <= 1'b1;
                     state           <= HOLD;
                  end else begin
                     illegal_click <= 1'b1;
                     state         <= IDLE;
                  end
               end
               HOLD: begin
                  if (click && on_board) begin
                     if (sq == sel_pos) begin
                        place_piece     <= 1'b1;
                        figure_position <= sel_pos;
                        sel_valid       <= 1'b0;
                        state           <= IDLE;
                     end else if (possible_moves[sq]) begin
                        place_piece     <= 1'b1;
                        figure_position <= sq;
                        sel_valid       <= 1'b0;
                        side_to_move    <= ~side_to_move;
                        move_count      <= sat_inc(move_count);
                        state           <= IDLE;
                     end else begin
                        illegal_click <= 1'b1;
                     end
                  end
               end
               OVER:    state <= OVER;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
